// File: rtl/change_req_pkg.sv
// change_req_pkg: controller state encodings, dwell width and the
// per-state dwell lookup shared by change_request_gen and its bench.
package change_req_pkg;

  localparam int DWELL_W = 8;

  typedef logic [3:0]         state_t;
  typedef logic [DWELL_W-1:0] dwell_t;

  localparam state_t ST_A = 4'd0;
  localparam state_t ST_B = 4'd1;
  localparam state_t ST_C = 4'd2;
  localparam state_t ST_D = 4'd3;
  localparam state_t ST_E = 4'd4;
  localparam state_t ST_F = 4'd5;

  function automatic dwell_t dwell_lookup(
    input state_t st,
    input dwell_t green,
    input dwell_t walk,
    input dwell_t yellow
  );
    dwell_t v;
    v = '0;
    case (st)
      ST_A, ST_D: v = green;
      ST_B, ST_E: v = walk;
      ST_C, ST_F: v = yellow;
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_request_gen_debounce.sv
// input_debouncer: 2-FF synchroniser plus stability counter.
// Ports: clock, resetn (sync, active-low), i_raw -> o_evt
// (rising-edge pulse when EDGE_MODE=1, debounced level otherwise).
module input_debouncer
  import change_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter bit EDGE_MODE       = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_raw,
  output logic o_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_sync2 ^ r_level;
  // Last of the required run of differing samples: accept it.
  assign w_done = w_diff && (r_cnt == LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= w_done & r_sync2;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_evt = EDGE_MODE ? r_rise : r_level;

endmodule

// File: rtl/change_request_gen.sv
// change_request_gen: debounced request latching, phase dwell timer
// and change handshake for the A-F light controller. Ports: clock,
// resetn, ped_btn1/2, [car_sense1/2], state -> change, wait1/2,
// secs_left. Macro CHANGE_REQ_CAR_SENSE_EN adds the car sensors.
module change_request_gen
  import change_req_pkg::*;
#(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MIN_GREEN       = 5,
  parameter int WALK_TIME       = 8,
  parameter int YELLOW_TIME     = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ped_btn1,
  input  logic       ped_btn2,
`ifdef CHANGE_REQ_CAR_SENSE_EN
  input  logic       car_sense1,
  input  logic       car_sense2,
`endif
  input  logic [3:0] state,
  output logic       change,
  output logic       wait1,
  output logic       wait2,
  output logic [7:0] secs_left
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam dwell_t LD_G = DWELL_W'(MIN_GREEN);
  localparam dwell_t LD_W = DWELL_W'(WALK_TIME);
  localparam dwell_t LD_Y = DWELL_W'(YELLOW_TIME);

  logic w_btn1;
  logic w_btn2;
  logic w_ev1;
  logic w_ev2;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .EDGE_MODE      (1'b1)
  ) u_db_btn1 (
    .clock (clock),
    .resetn(resetn),
    .i_raw (ped_btn1),
    .o_evt (w_btn1)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .EDGE_MODE      (1'b1)
  ) u_db_btn2 (
    .clock (clock),
    .resetn(resetn),
    .i_raw (ped_btn2),
    .o_evt (w_btn2)
  );

`ifdef CHANGE_REQ_CAR_SENSE_EN
  logic w_car1;
  logic w_car2;

  // Presence is level-sensitive: a parked car keeps requesting.
  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .EDGE_MODE      (1'b0)
  ) u_db_car1 (
    .clock (clock),
    .resetn(resetn),
    .i_raw (car_sense1),
    .o_evt (w_car1)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .EDGE_MODE      (1'b0)
  ) u_db_car2 (
    .clock (clock),
    .resetn(resetn),
    .i_raw (car_sense2),
    .o_evt (w_car2)
  );

  assign w_ev1 = w_btn1 | w_car1;
  assign w_ev2 = w_btn2 | w_car2;
`else
  assign w_ev1 = w_btn1;
  assign w_ev2 = w_btn2;
`endif

  logic          r_started;
  state_t        r_state_q;
  logic [PW-1:0] r_pre;
  dwell_t        r_dwell;
  logic          r_change;
  logic          r_wait1;
  logic          r_wait2;

  logic w_valid;
  logic w_entry;
  logic w_tick;
  logic w_adv;

  assign w_valid = (state <= ST_F);
  // r_started makes the first post-reset cycle count as an entry.
  assign w_entry = (state != r_state_q) | ~r_started;
  assign w_tick  = (r_pre == P_LAST);

  // Dwell of zero read on an entry cycle is stale, so exclude it.
  always_comb begin
    w_adv = 1'b0;
    if (w_valid && !w_entry && (r_dwell == '0)) begin
      unique case (1'b1)
        (state == ST_A): w_adv = r_wait1;
        (state == ST_D): w_adv = r_wait2;
        default:         w_adv = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_started <= 1'b0;
      r_state_q <= ST_A;
      r_pre     <= '0;
      r_dwell   <= '0;
      r_change  <= 1'b0;
      r_wait1   <= 1'b0;
      r_wait2   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_state_q <= state;
      if (!w_valid) begin
        r_pre    <= '0;
        r_dwell  <= '0;
        r_change <= 1'b0;
      end else begin
        if (w_entry) begin
          r_pre    <= '0;
          r_dwell  <= dwell_lookup(state, LD_G, LD_W, LD_Y);
          r_change <= 1'b0;
        end else begin
          r_pre <= w_tick ? '0 : r_pre + PW'(1);
          if (w_tick && (r_dwell != '0)) begin
            r_dwell <= r_dwell - DWELL_W'(1);
          end
          if (w_adv) begin
            r_change <= 1'b1;
          end
        end
        // Clear on service entry takes priority over a new event.
        if (w_entry && (state == ST_D)) begin
          r_wait1 <= 1'b0;
        end else if (w_ev1 && (state != ST_D)) begin
          r_wait1 <= 1'b1;
        end
        if (w_entry && (state == ST_A)) begin
          r_wait2 <= 1'b0;
        end else if (w_ev2 && (state != ST_A)) begin
          r_wait2 <= 1'b1;
        end
      end
    end
  end

  assign change    = r_change;
  assign wait1     = r_wait1;
  assign wait2     = r_wait2;
  assign secs_left = r_dwell;

endmodule

// File: tb/tb_change_request_gen.sv
// tb_change_request_gen: directed bench with a light-controller model
// that advances state one cycle after seeing change=1.
module tb_change_request_gen;
  import change_req_pkg::*;

  logic       clock     = 1'b0;
  logic       resetn    = 1'b0;
  logic       ped_btn1  = 1'b0;
  logic       ped_btn2  = 1'b0;
`ifdef CHANGE_REQ_CAR_SENSE_EN
  logic       car_sense1 = 1'b0;
  logic       car_sense2 = 1'b0;
`endif
  logic [3:0] state     = ST_A;
  logic       change;
  logic       wait1;
  logic       wait2;
  logic [7:0] secs_left;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  bit auto_adv = 1'b1;

  always #5 clock = ~clock;

  change_request_gen #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3),
    .MIN_GREEN      (2),
    .WALK_TIME      (2),
    .YELLOW_TIME    (1)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .ped_btn1  (ped_btn1),
    .ped_btn2  (ped_btn2),
`ifdef CHANGE_REQ_CAR_SENSE_EN
    .car_sense1(car_sense1),
    .car_sense2(car_sense2),
`endif
    .state     (state),
    .change    (change),
    .wait1     (wait1),
    .wait2     (wait2),
    .secs_left (secs_left)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (auto_adv && change && (state <= ST_F)) begin
        state = (state == ST_F) ? ST_A : state + 4'd1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    state  = ST_A;
    cyc(3);
    chk("rst_change", {7'd0, change}, 8'd0);
    chk("rst_wait1", {7'd0, wait1}, 8'd0);
    chk("rst_wait2", {7'd0, wait2}, 8'd0);
    chk("rst_secs", secs_left, 8'd0);

    resetn = 1'b1;
    cyc(1);
    chk("A_load", secs_left, 8'd2);
    cyc(3);
    chk("A_hold", secs_left, 8'd2);
    cyc(1);
    chk("A_dec1", secs_left, 8'd1);
    cyc(4);
    chk("A_zero", secs_left, 8'd0);
    cyc(10);
    chk("A_rest_chg", {7'd0, change}, 8'd0);
    chk("A_rest_secs", secs_left, 8'd0);

    ped_btn1 = 1'b1;
    cyc(2);
    ped_btn1 = 1'b0;
    cyc(8);
    chk("glitch_wait1", {7'd0, wait1}, 8'd0);
    chk("glitch_chg", {7'd0, change}, 8'd0);

    ped_btn1 = 1'b1;
    cyc(4);
    ped_btn1 = 1'b0;
    cyc(1);
    chk("lat5_wait1", {7'd0, wait1}, 8'd0);
    cyc(1);
    chk("lat6_wait1", {7'd0, wait1}, 8'd1);
    chk("lat6_chg", {7'd0, change}, 8'd0);
    cyc(1);
    chk("A_chg", {7'd0, change}, 8'd1);
    cyc(1);
    chk("B_entry_chg", {7'd0, change}, 8'd0);
    chk("B_entry_secs", secs_left, 8'd2);
    cyc(8);
    chk("B_zero_secs", secs_left, 8'd0);
    chk("B_zero_chg", {7'd0, change}, 8'd0);
    cyc(1);
    chk("B_chg", {7'd0, change}, 8'd1);
    cyc(1);
    chk("C_entry_secs", secs_left, 8'd1);
    cyc(5);
    chk("C_chg", {7'd0, change}, 8'd1);
    cyc(1);
    chk("D_wait1_clr", {7'd0, wait1}, 8'd0);
    chk("D_entry_secs", secs_left, 8'd2);

    ped_btn1 = 1'b1;
    cyc(4);
    ped_btn1 = 1'b0;
    cyc(8);
    chk("D_press_ign", {7'd0, wait1}, 8'd0);
    chk("D_rest_chg", {7'd0, change}, 8'd0);
    chk("D_rest_secs", secs_left, 8'd0);

    ped_btn2 = 1'b1;
    cyc(4);
    ped_btn2 = 1'b0;
    cyc(2);
    chk("D_wait2_set", {7'd0, wait2}, 8'd1);
    cyc(1);
    chk("D_chg", {7'd0, change}, 8'd1);
    cyc(1);
    chk("E_entry_secs", secs_left, 8'd2);
    ped_btn1 = 1'b1;
    cyc(4);
    ped_btn1 = 1'b0;
    cyc(2);
    chk("E_wait1_set", {7'd0, wait1}, 8'd1);
    cyc(10);
    chk("A2_wait2_clr", {7'd0, wait2}, 8'd0);
    chk("A2_wait1_kept", {7'd0, wait1}, 8'd1);
    chk("A2_entry_secs", secs_left, 8'd2);
    cyc(9);
    chk("A2_chg", {7'd0, change}, 8'd1);
    cyc(1);

    ped_btn1 = 1'b1;
    ped_btn2 = 1'b1;
    cyc(4);
    ped_btn1 = 1'b0;
    ped_btn2 = 1'b0;
    cyc(2);
    chk("B2_wait1", {7'd0, wait1}, 8'd1);
    chk("B2_wait2", {7'd0, wait2}, 8'd1);
    cyc(10);
    chk("D2_wait1_clr", {7'd0, wait1}, 8'd0);
    chk("D2_wait2_kept", {7'd0, wait2}, 8'd1);
    cyc(26);
    chk("A3_wait2_clr", {7'd0, wait2}, 8'd0);
    chk("A3_wait1", {7'd0, wait1}, 8'd0);
    chk("A3_entry_secs", secs_left, 8'd2);
    cyc(10);
    chk("A3_rest_chg", {7'd0, change}, 8'd0);

    auto_adv = 1'b0;
    ped_btn1 = 1'b1;
    cyc(4);
    ped_btn1 = 1'b0;
    cyc(2);
    chk("hold_wait1", {7'd0, wait1}, 8'd1);
    chk("hold_pre_chg", {7'd0, change}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hold_chg", {7'd0, change}, 8'd1);
    end
    state    = ST_B;
    auto_adv = 1'b1;
    cyc(1);
    chk("hold_drop", {7'd0, change}, 8'd0);
    chk("hold_B_secs", secs_left, 8'd2);

    cyc(2);
    resetn = 1'b0;
    state  = ST_A;
    cyc(1);
    chk("mid_rst_chg", {7'd0, change}, 8'd0);
    chk("mid_rst_wait1", {7'd0, wait1}, 8'd0);
    chk("mid_rst_wait2", {7'd0, wait2}, 8'd0);
    chk("mid_rst_secs", secs_left, 8'd0);
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    chk("rel_secs", secs_left, 8'd2);

    state = 4'd9;
    cyc(1);
    chk("bad_secs", secs_left, 8'd0);
    cyc(3);
    chk("bad_chg", {7'd0, change}, 8'd0);

`ifdef CHANGE_REQ_CAR_SENSE_EN
    state      = ST_D;
    car_sense2 = 1'b1;
    cyc(1);
    chk("car_D_secs", secs_left, 8'd2);
    cyc(5);
    chk("car_wait2", {7'd0, wait2}, 8'd1);
    cyc(4);
    chk("car_chg", {7'd0, change}, 8'd1);
    car_sense2 = 1'b0;
    cyc(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/change_request_gen.md
# change_request_gen

Request-side front end for the intersection controller. It synchronises and debounces the raw pedestrian push-buttons and vehicle presence sensors, latches per-direction service requests, and times the dwell of each phase. It produces the `change` advance request consumed by the 6-state light controller (states A–F), completing the loop with that controller's `state` output. It also drives per-direction "wait" indicators and a seconds-remaining count for display.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per one-second tick.
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable synchronised cycles needed to accept an input level.
- `MIN_GREEN`, 5: seconds of minimum green in A/D.
- `WALK_TIME`, 8: seconds of flashing-walk in B/E.
- `YELLOW_TIME`, 3: seconds of yellow in C/F.
- `clock` in 1: system clock (50 MHz).
- `resetn` in 1: reset, synchronous, active-low; clock `clock`.
- `ped_btn1` in 1: raw async button, direction 1 (served in D).
- `ped_btn2` in 1: raw async button, direction 2 (served in A).
- `car_sense1` in 1: raw async presence, direction 1 (only with `CHANGE_REQ_CAR_SENSE_EN`).
- `car_sense2` in 1: raw async presence, direction 2 (only with `CHANGE_REQ_CAR_SENSE_EN`).
- `state` in 4: controller state; A=0, B=1, C=2, D=3, E=4, F=5.
- `change` out 1: level advance request to the controller.
- `wait1` out 1: direction-1 request latched.
- `wait2` out 1: direction-2 request latched.
- `secs_left` out 8: remaining dwell seconds, unsigned, saturating at 0.

## Operation
- Inputs pass through a 2-FF synchroniser, then a debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive cycles of a new synchronised value.
- Button events are accepted on the debounced rising edge only. Car-sensor events are accepted while the debounced level is high.
- `wait1` sets on a direction-1 event in any state except D; events in D are ignored. It clears on entry to D.
- `wait2` sets on a direction-2 event in any state except A; events in A are ignored. It clears on entry to A.
- If set and clear occur in the same cycle, clear wins.
- State entry is detected as `state` differing from its registered copy. On entry:
  - the dwell counter loads MIN_GREEN for A/D, WALK_TIME for B/E, YELLOW_TIME for C/F;
  - the tick prescaler restarts at 0.
- The prescaler counts `clock` cycles from 0 to TICK_DIV−1. At terminal count it wraps and decrements the dwell counter if the counter is nonzero.
- Advance condition (dwell == 0):
  - B, C, E, F: always advance.
  - A: advance only if `wait1`.
  - D: advance only if `wait2`.
  - A or D with no opposing request: rest in green indefinitely, `secs_left` holds 0.
- Handshake:
  - `change` rises in the cycle after the advance condition becomes true.
  - It stays high until a state change is detected, then drops in that same cycle's registered update.
  - It is never deasserted before the state changes.
- `state` values 6–15: `change`=0, dwell counter and prescaler held at 0, wait flags hold their values.

## Timing
- Reset values: `change`=0, `wait1`=0, `wait2`=0, `secs_left`=0, dwell=0, prescaler=0, synchroniser/debouncer state=0, registered state copy=A. Reset is also applied mid-operation.
- On the first cycle after reset release with `state`=A, A counts as entered: dwell loads MIN_GREEN.
- Button-to-`waitN` latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Dwell-zero to `change` high: 1 cycle.
- State change to `change` low: 1 cycle.
- `secs_left` is the dwell counter, registered, with no extra latency.

## Configuration
- `CHANGE_REQ_CAR_SENSE_EN` defined: car-sensor ports exist and each is ORed into its direction's request.
- Not defined: the `car_sense1`/`car_sense2` ports and their debouncers are absent, and requests come from buttons only.

## Structure
- Package `change_req_pkg` holds:
  - state encodings ST_A..ST_F (4-bit);
  - dwell width (8);
  - a dwell-lookup function mapping state to load value.
- Sub-module `input_debouncer` holds the 2-FF sync, stability counter (sized by `$clog2(DEBOUNCE_CYCLES+1)`), debounced level and a rising-edge pulse. It is instantiated 2× without the macro and 4× with it.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_CYCLES=3, MIN_GREEN=2, WALK_TIME=2, YELLOW_TIME=1. The bench model advances `state` one cycle after seeing `change`=1.
- Reset with `state`=A and no presses → `change` stays 0 indefinitely; `secs_left` 2→1→0 over 8 cycles, then holds 0.
- `ped_btn1` held for 4 cycles in A → `wait1`=1 at cycle 6 after the press. `change` rises once dwell is 0. The sequence A→B→C→D follows. `wait1` clears on D entry.
- `ped_btn1` glitch of 2 cycles → `wait1` stays 0.
- `ped_btn1` pressed in D → ignored, `wait1`=0. Pressed in E → `wait1`=1.
- `ped_btn1` and `ped_btn2` accepted simultaneously in B → both waits set. D is served, `wait1` clears, then A is reached, `wait2` clears.
- Bench withholds the state advance for 10 cycles → `change` stays 1 for 10 cycles, then drops 1 cycle after the advance. `resetn`=0 mid-phase → all outputs 0 next cycle.
- With `CHANGE_REQ_CAR_SENSE_EN`: `car_sense2` held high in D → `wait2`=1 and A follows after MIN_GREEN.
